// File: rtl/sdhost_int_status_ctrl_pkg.sv
// Shared definitions for the SD host Normal Interrupt Status (030h) controller:
// bit positions, reserved/W1C masks and the host-write FSM state type.
package sdhost_pkg;

  localparam int CMD_COMPLETE  = 0;
  localparam int XFER_COMPLETE = 1;
  localparam int BLK_GAP_EVENT = 2;
  localparam int DMA_INT       = 3;
  localparam int BUF_WR_READY  = 4;
  localparam int BUF_RD_READY  = 5;
  localparam int CARD_INSERT   = 6;
  localparam int CARD_REMOVE   = 7;
  localparam int CARD_INT      = 8;
  localparam int ERR_INT       = 15;

  localparam logic [15:0] NIS_RSVD_MASK = 16'h7E00;
  localparam logic [15:0] NIS_W1C_MASK  = 16'h00FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACK   = 2'd2,
    WAIT  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/sdhost_int_status_ctrl_if.sv
// Register-side bus of the 030h status controller: host W1C handshake,
// enable masks from 034h/038h, and the status image / interrupt line back.
interface sdhost_int_status_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic [WIDTH-1:0] stat_en;
  logic [WIDTH-1:0] sig_en;
  logic [WIDTH-1:0] status_out;
  logic             irq;

  modport master (
    output wr_req, wr_data, stat_en, sig_en,
    input  wr_ack, status_out, irq
  );

  modport slave (
    input  wr_req, wr_data, stat_en, sig_en,
    output wr_ack, status_out, irq
  );
endinterface

// File: rtl/sdhost_int_status_ctrl_coalesce.sv
// Interrupt coalescing stage: irq only asserts after pending has been held
// for COAL_CYCLES clocks. Used only when SDHOST_IRQ_COALESCE_EN is defined.
module sdhost_irq_coalesce #(
  parameter int COAL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  output logic irq
);

  localparam logic [7:0] LIMIT = 8'(COAL_CYCLES);

  logic [7:0] coalCnt;

  // Counter saturates at LIMIT so a long-held pending keeps irq asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      coalCnt <= 8'd0;
      irq     <= 1'b0;
    end else if (!pending) begin
      coalCnt <= 8'd0;
      irq     <= 1'b0;
    end else begin
      if (coalCnt != LIMIT) begin
        coalCnt <= coalCnt + 8'd1;
      end
      irq <= (coalCnt == LIMIT);
    end
  end

endmodule

// File: rtl/sdhost_int_status_ctrl.sv
// SD host Normal Interrupt Status (030h) controller: sticky event bits, enable
// masking, W1C host writes and the host irq. Optional macro: SDHOST_IRQ_COALESCE_EN.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no write in flight; wr_req captures wr_data
//   CLEAR | captured W1C mask is applied to the sticky bits
//   ACK   | wr_ack pulses for one cycle
//   WAIT  | hold until the host drops wr_req
module sdhost_int_status_ctrl
  import sdhost_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int COAL_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            event_in,
  input  logic                        err_any,
  input  logic                        card_int,
  sdhost_int_status_ctrl_if.slave     bus
);

  wr_state_t        wrState;
  wr_state_t        wrNext;
  logic [7:0]       wdCap;
  logic             clrEn;
  logic             ackOut;

  logic [7:0]       sticky;
  logic [7:0]       setVec;
  logic [7:0]       clrVec;
  logic             cardBit;
  logic             errBit;
  logic [WIDTH-1:0] statusImg;
  logic             pending;
  logic             irqOut;
  logic             unusedBits;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrState <= IDLE;
    end else begin
      wrState <= wrNext;
    end
  end

  always_comb begin
    wrNext = wrState;
    case (wrState)
      IDLE:    if (bus.wr_req) wrNext = CLEAR;
      CLEAR:   wrNext = ACK;
      ACK:     wrNext = WAIT;
      WAIT:    if (!bus.wr_req) wrNext = IDLE;
      default: wrNext = IDLE;
    endcase
  end

  always_comb begin
    clrEn  = 1'b0;
    ackOut = 1'b0;
    case (wrState)
      CLEAR:   clrEn  = 1'b1;
      ACK:     ackOut = 1'b1;
      default: begin
        clrEn  = 1'b0;
        ackOut = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdCap <= 8'h00;
    end else if (wrState == IDLE && bus.wr_req) begin
      wdCap <= bus.wr_data[7:0];
    end
  end

  assign setVec = event_in[7:0] & bus.stat_en[7:0];
  assign clrVec = clrEn ? (wdCap & NIS_W1C_MASK[7:0]) : 8'h00;

  // A set in the clear cycle wins; dropping a Status Enable bit wipes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky  <= 8'h00;
      cardBit <= 1'b0;
      errBit  <= 1'b0;
    end else begin
      sticky  <= setVec | (sticky & ~clrVec & bus.stat_en[7:0]);
      cardBit <= card_int & bus.stat_en[CARD_INT];
      errBit  <= err_any;
    end
  end

  always_comb begin
    statusImg           = '0;
    statusImg[7:0]      = sticky;
    statusImg[CARD_INT] = cardBit;
    statusImg[ERR_INT]  = errBit;
    statusImg           = statusImg & ~NIS_RSVD_MASK;
  end

  assign pending = |(statusImg & bus.sig_en);

`ifdef SDHOST_IRQ_COALESCE_EN
  sdhost_irq_coalesce #(
    .COAL_CYCLES (COAL_CYCLES)
  ) u_coalesce (
    .clk     (clk),
    .rst     (rst),
    .pending (pending),
    .irq     (irqOut)
  );

  assign unusedBits = ^{event_in[WIDTH-1:8], bus.wr_data[WIDTH-1:8],
                        bus.stat_en[WIDTH-1:9]};
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      irqOut <= 1'b0;
    end else begin
      irqOut <= pending;
    end
  end

  // Coalescing depth has no meaning without the coalescing stage.
  assign unusedBits = ^{event_in[WIDTH-1:8], bus.wr_data[WIDTH-1:8],
                        bus.stat_en[WIDTH-1:9], 8'(COAL_CYCLES)};
`endif

  assign bus.status_out = statusImg;
  assign bus.wr_ack     = ackOut;
  assign bus.irq        = irqOut;

endmodule

// File: doc/sdhost_int_status_ctrl.md
# sdhost_int_status_ctrl

Controller for the SD Host Normal Interrupt Status register (offset 030h). It turns single-cycle event pulses from the command/data/DMA datapath into sticky status bits. It applies the Status Enable (034h) and Signal Enable (038h) masks, services host write-1-to-clear requests through a req/ack handshake, and drives the host interrupt line. `status_out` feeds the `*_in` inputs of the 030h register block.

## Interface
- `WIDTH`, 16, status register width.
- `COAL_CYCLES`, 8, coalescing delay in clocks; used only when `SDHOST_IRQ_COALESCE_EN` is defined. Legal range 1..255.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `event_in`  in  16  one-cycle event pulses, bit map of 030h; bits 8 and 15:9 are ignored.
- `err_any`  in  1  level, OR of Error Interrupt Status (032h).
- `card_int`  in  1  level, card interrupt from DAT[1].
- `stat_en`  in  16  Status Enable mask (034h).
- `sig_en`  in  16  Signal Enable mask (038h).
- `wr_req`  in  1  host W1C write request, held high until `wr_ack`.
- `wr_data`  in  16  W1C data, sampled on the IDLE->CLEAR transition.
- `wr_ack`  out  1  single-cycle write acknowledge.
- `status_out`  out  16  current status image.
- `irq`  out  1  host interrupt, registered.

## Operation
- Bits 7:0 are sticky:
  - The bit sets when `event_in[i] & stat_en[i]` is true.
  - The bit clears by W1C.
  - The bit also clears on the cycle after `stat_en[i]` goes low.
- Bit 8 = `card_int & stat_en[8]`. It is not latched and W1C has no effect.
- Bit 15 = `err_any`. It is not latched and W1C has no effect.
- Bits 14:9 are always 0.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Write FSM (2-bit state):
  - IDLE: when `wr_req` is high, capture `wr_data` and go to CLEAR.
  - CLEAR: apply `status[7:0] &= ~wd[7:0]`, go to ACK.
  - ACK: `wr_ack` = 1, go to WAIT.
  - WAIT: stay until `wr_req` = 0, then go to IDLE.
- `pending = |(status_out & sig_en)`. Without coalescing, `irq` <= `pending`.
- Reset mid-write: FSM returns to IDLE, `wr_ack` drops, no clear is applied, and the captured data is discarded.

## Timing
- Reset values:
  - `status_out` = 16'h0000
  - `irq` = 0
  - `wr_ack` = 0
  - FSM = IDLE
  - coalescing counter = 0
- Event pulse at cycle N: `status_out` bit is high at N+1, `irq` is high at N+2.
- `wr_req` first high at cycle N:
  - CLEAR during N+1.
  - Bit low at N+2.
  - `wr_ack` high for cycle N+2 only.
  - `irq` low at N+3 if no other bit is pending.
- `card_int` or `err_any` change at N: `status_out` follows at N+1.
- `wr_ack` is never high for two consecutive cycles. A new request is accepted no earlier than the cycle after `wr_req` is seen low in WAIT.

## Configuration
- `SDHOST_IRQ_COALESCE_EN` defined:
  - An 8-bit counter increments while `pending` = 1.
  - `irq` asserts once the counter reaches `COAL_CYCLES`.
  - Any cycle with `pending` = 0 resets the counter to 0 and deasserts `irq` on the next edge.
  - The counter saturates at `COAL_CYCLES`.
- Not defined: `irq` is the registered `pending` with a fixed 1-cycle latency; there is no counter logic.

## Structure
- Shared package `sdhost_pkg`:
  - bit-index constants: `CMD_COMPLETE` = 0 … `CARD_INT` = 8, `ERR_INT` = 15
  - `NIS_RSVD_MASK` = 16'h7E00 and `NIS_W1C_MASK` = 16'h00FF
  - enum `wr_state_t` {IDLE, CLEAR, ACK, WAIT}
- One sub-module, `sdhost_irq_coalesce`, holds the counter and `irq` register. It is instantiated only under the macro.

## Test plan
- After reset, pulse `event_in` = 16'h0001 with `stat_en` = `sig_en` = 16'hFFFF -> `status_out` = 16'h0001 next cycle, `irq` = 1 the cycle after.
- With status 16'h0003, W1C `wr_data` = 16'h0001 -> `status_out` = 16'h0002 two cycles after request, one `wr_ack` pulse, `irq` stays 1.
- Pulse `event_in[1]` in the CLEAR cycle of a W1C 16'h0002 -> bit 1 remains 1.
- Set `stat_en` = 16'h0000 with bits 7:0 = 8'hFF -> `status_out[7:0]` = 0 next cycle. Then pulse events -> no set, `irq` = 0.
- `card_int` = 1, `err_any` = 1, W1C 16'hFFFF -> `status_out` = 16'h8100 unchanged. Drop both -> 16'h0000 next cycle.
- Assert `rst` during ACK -> `wr_ack` = 0, `status_out` = 0, FSM IDLE. With the macro and `COAL_CYCLES` = 8, `irq` rises exactly 9 cycles after the status bit sets.
